instr_fetch_unit: RTL

//   Instruction-fetch initiator for the byte-addressed, big-endian instruction ROM (active-low

---
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch initiator for the big-endian instruction ROM.
// Holds the PC, issues one combinational ROM read per cycle, and registers
// {instr, instr_pc} toward decode under a valid/ready handshake. Redirects
// retarget the PC and flush the held word. A HALT opcode or an illegal
// fetch address stops fetching until the next redirect or reset.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ROM_BYTES   = 100,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        clk,
    input  logic        nrst,
    output logic        rom_nrd,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    // 33-bit compare so pc+3 can never wrap into the legal window.
    localparam logic [32:0] ROM_LIMIT = 33'(ROM_BYTES);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        valid_q;
    logic        halted_q;
    logic        fault_q;

    logic [31:0] pc_d;
    logic        can_take;
    logic        pc_ok;
    logic        fire;

    // Fetch qualification: room downstream, legal address, running, not redirecting.
    always_comb begin
        can_take = !valid_q || instr_ready;
        pc_ok    = (pc_q[1:0] == 2'b00) && (({1'b0, pc_q} + 33'd3) < ROM_LIMIT);
        fire     = nrst && (state_q == ST_RUN) && !redirect && pc_ok && can_take;
        pc_d     = pc_q + 32'd4;
    end

    assign rom_nrd     = !fire;
    assign rom_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign fault       = fault_q;

    // Control FSM and datapath registers; priority reset > redirect > fetch/fault > handshake.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values;
        // blocking here would let later statements see half-updated state.
        if (!nrst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else if (redirect) begin
            // Held word is dropped even if decode would have taken it this edge.
            pc_q     <= redirect_pc;
            valid_q  <= 1'b0;
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else if (fire) begin
            // A fire also retires any accepted word: replacement without a bubble.
            instr_q    <= rom_data;
            instr_pc_q <= pc_q;
            valid_q    <= 1'b1;
            pc_q       <= pc_d;
            if (rom_data[31:26] == HALT_OPCODE) begin
                state_q  <= ST_HALT;
                halted_q <= 1'b1;
            end
        end else begin
            if (state_q == ST_RUN && !pc_ok) begin
                // pc is left pointing at the offending address.
                state_q <= ST_FAULT;
                fault_q <= 1'b1;
            end
            if (valid_q && instr_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule
